// File: rtl/mult_pipe.sv
// mult_pipe: three-stage pipelined WIDTH x WIDTH multiplier with a valid/ready
// handshake on both sides.
//   S1: AND-array partial products (plus signed correction terms)
//   S2: carry-save compression of all rows down to sum/carry rows
//   S3: Kogge-Stone prefix addition, registered into out_p
// Optional feature macro: MULT_SIGNED_EN. When it is defined, in_signed selects
// a two's-complement product using modified Baugh-Wooley. When it is undefined,
// in_signed is ignored and no correction logic is built.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_x, in_y operands, in_signed mode
//   out_valid/out_ready output handshake; out_p product (PW bits)
//   busy                any stage holds a transaction
module mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_p,
  output logic             busy
);

`ifdef MULT_SIGNED_EN
  localparam int unsigned NROW = WIDTH + 1;  // extra row carries the correction constant
`else
  localparam int unsigned NROW = WIDTH;
`endif
  localparam int unsigned LOGPW = $clog2(PW);

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  logic [PW-1:0] pp_d [NROW];
  logic [PW-1:0] pp_q [NROW];
  logic [PW-1:0] csa_s, csa_c;
  logic [PW-1:0] sum_q, car_q;
  logic [PW-1:0] add_res;

  // A stage may accept when it is empty or its contents move on this cycle
  assign rdy3      = !v3 || out_ready;
  assign rdy2      = !v2 || rdy3;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = !rst && rdy1;
  assign out_valid = v3;
  assign busy      = v1 || v2 || v3;

`ifdef MULT_SIGNED_EN
  logic sgn;
  assign sgn = in_signed;
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  // S1 combinational: partial product rows, row j weighted by in_y[j]
  always_comb begin
    for (int unsigned j = 0; j < NROW; j++) begin
      pp_d[j] = '0;
    end
    for (int unsigned j = 0; j < WIDTH; j++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pp_d[j][i+j] = in_x[i] & in_y[j];
`ifdef MULT_SIGNED_EN
        // Terms mixing exactly one sign bit carry negative weight: invert them
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
          pp_d[j][i+j] = ~(in_x[i] & in_y[j]);
        end
`endif
      end
    end
`ifdef MULT_SIGNED_EN
    // Constant 2^WIDTH + 2^(PW-1) compensates the inverted terms
    if (sgn) begin
      pp_d[WIDTH][WIDTH] = 1'b1;
      pp_d[WIDTH][PW-1]  = 1'b1;
    end
`endif
  end

  // S2 combinational: full-adder array folds one row per level into sum/carry
  always_comb begin
    logic [PW-1:0] t;
    csa_s = pp_q[0];
    csa_c = pp_q[1];
    for (int unsigned k = 2; k < NROW; k++) begin
      t     = csa_s ^ csa_c ^ pp_q[k];
      csa_c = ((csa_s & csa_c) | (csa_s & pp_q[k]) | (csa_c & pp_q[k])) << 1;
      csa_s = t;
    end
  end

  // S3 combinational: Kogge-Stone carry computation over PW bits
  always_comb begin
    logic [PW-1:0] g, p, p0;
    g  = sum_q & car_q;
    p  = sum_q ^ car_q;
    p0 = p;
    for (int unsigned k = 0; k < LOGPW; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & (p << (1 << k));
    end
    add_res = p0 ^ (g << 1);
  end

  // Stage valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= (in_valid && in_ready) || (v1 && !rdy2);
      v2 <= (v1 && rdy2) || (v2 && !rdy3);
      v3 <= (v2 && rdy3) || (v3 && !out_ready);
    end
  end

  // S1/S2 datapath registers (no reset needed)
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int unsigned j = 0; j < NROW; j++) begin
        pp_q[j] <= pp_d[j];
      end
    end
    if (v1 && rdy2) begin
      sum_q <= csa_s;
      car_q <= csa_c;
    end
  end

  // S3 result register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p <= '0;
    end else if (v2 && rdy3) begin
      out_p <= add_res;
    end
  end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 4 to 32.
REQ-002 The module SHALL have parameter PW, default 2*WIDTH, giving the product width; it is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 in_valid  input  1  Operand pair present.
REQ-006 in_ready  output  1  Block can accept an operand pair this cycle.
REQ-007 in_x  input  WIDTH  Multiplicand.
REQ-008 in_y  input  WIDTH  Multiplier.
REQ-009 in_signed  input  1  Selects two's-complement operands for this transaction.
REQ-010 out_valid  output  1  Product present.
REQ-011 out_ready  input  1  Consumer accepts the product.
REQ-012 out_p  output  PW  Product.
REQ-013 busy  output  1  High while any pipeline stage holds a valid transaction.

Function
REQ-014 Transfer SHALL occur on a rising edge where valid and ready are both high, on either port.
REQ-015 The pipeline SHALL have 3 registered stages:
- S1: AND-array partial products, with signed correction terms.
- S2: carry-save compression (HA/FA tree) to two rows of PW bits.
- S3: PW-bit parallel-prefix addition, registered into out_p.
REQ-016 Latency SHALL be exactly 3 cycles from input transfer to out_valid while out_ready is held high.
REQ-017 Throughput SHALL be one transaction per cycle with no bubbles while out_ready is high.
REQ-018 A stage SHALL advance when its successor is empty or is advancing in the same cycle.
REQ-019 in_ready SHALL be low only when S1 is valid and cannot advance.
REQ-020 Backpressure: while out_valid is high and out_ready is low, out_p and out_valid SHALL hold stable, and no transaction SHALL be dropped or duplicated.
REQ-021 Unsigned mode SHALL give out_p = in_x*in_y as exact PW-bit unsigned.
REQ-022 Signed mode SHALL give the exact PW-bit two's-complement product; no overflow is possible.
REQ-023 in_signed SHALL be captured with its operands and SHALL travel with the transaction.
REQ-024 Simultaneous output transfer and input transfer with a full pipeline SHALL be legal: all stages shift and the new pair enters S1.
REQ-025 busy SHALL be the OR of the S1, S2 and S3 valid bits.

Reset
REQ-026 While rst is high: all stage valid bits = 0, out_valid = 0, out_p = 0, busy = 0, in_ready = 0.
REQ-027 The first cycle after rst deasserts SHALL have in_ready = 1.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear on the output after reset.
REQ-029 Datapath registers other than out_p need not be reset.

Configuration
REQ-030 Macro MULT_SIGNED_EN:
- Defined: in_signed is honoured per REQ-022.
- Undefined: the in_signed port SHALL remain present but be ignored; all transactions are unsigned and no signed-correction logic is built.

Verification (WIDTH=8)
REQ-031 Unsigned x=255, y=255, out_ready=1 -> out_p=0xFE01 exactly 3 cycles after the transfer.
REQ-032 MULT_SIGNED_EN defined, in_signed=1:
- x=0x80, y=0x80 -> 0x4000.
- x=0xFF, y=0x01 -> 0xFFFF.
- Same pairs with in_signed=0 -> 0x4000 and 0x00FF.
REQ-033 Back-to-back pairs (3,5), (7,9), (15,15), (0,200) with out_ready=1 -> products 15, 63, 225, 0 on consecutive cycles 3-6.
REQ-034 Backpressure: 5 pairs offered, out_ready=0 for 6 cycles, then 1 ->
- in_ready low after the 3rd accept.
- All 5 products delivered in order.
- out_p stable while stalled.
REQ-035 Reset mid-operation: assert rst with 3 transactions in flight -> out_valid=0 and busy=0 the next cycle, and no stale product afterwards.
REQ-036 MULT_SIGNED_EN undefined: x=0xFF, y=0xFF with in_signed=1 -> 0xFE01.
